// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared register map and control constants for the PWM block
package pwm_pkg;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_PRESCALE = 8'h01;
  localparam logic [7:0] ADDR_PERIOD   = 8'h02;
  localparam logic [7:0] ADDR_ID       = 8'h03;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;

  localparam logic [7:0] DUTY_BASE_DEFAULT = 8'h10;
  localparam logic [7:0] ID_VALUE_DEFAULT  = 8'hA5;

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM output with double-buffered duty and registered compare
module pwm_channel
  import pwm_pkg::*;
(
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic       en_i,
  input  logic       inv_i,
  input  logic       load_i,
  input  logic [7:0] duty_i,
  input  logic [7:0] cnt_i,
  output logic       pwm_o
);

  logic [7:0] duty_act_q;

  // Active duty follows the shadow while disabled and at every period wrap
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      duty_act_q <= 8'h00;
    end else if (load_i) begin
      duty_act_q <= duty_i;
    end
  end

  // Registered compare keeps the output glitch-free; disabled drives the idle level
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= en_i ? ((cnt_i < duty_act_q) ^ inv_i) : inv_i;
    end
  end

endmodule

// File: rtl/pwm_regbank.sv
// rtl/pwm_regbank.sv - register bank, prescaler and period counter driving NUM_CH PWM channels
module pwm_regbank
  import pwm_pkg::*;
#(
  parameter int         NUM_CH    = 8,
  parameter logic [7:0] DUTY_BASE = DUTY_BASE_DEFAULT,
  parameter logic [7:0] ID_VALUE  = ID_VALUE_DEFAULT
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic [7:0]        b_addr_i,
  input  logic [7:0]        b_data_i,
  input  logic              b_write_i,
  output logic [7:0]        b_data_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_o
);

  logic             wr_q;
  logic             commit;
  logic [1:0]       ctrl_q;
  logic [7:0]       prescale_q;
  logic [7:0]       period_sh_q;
  logic [7:0]       period_act_q;
  logic [7:0]       duty_sh_q [NUM_CH];
  logic [7:0]       pcnt_q;
  logic [7:0]       cnt_q;
  logic             en;
  logic             inv;
  logic             tick;
  logic             wrap;
  logic             load_act;

  assign en       = ctrl_q[CTRL_EN];
  assign inv      = ctrl_q[CTRL_INV];
  assign commit   = b_write_i & ~wr_q;
  assign tick     = en & (pcnt_q >= prescale_q);
  assign wrap     = tick & (cnt_q >= period_act_q);
  assign load_act = ~en | wrap;
  assign period_o = wrap;

  // Edge-detect the write level and commit one write per rising edge
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wr_q        <= 1'b0;
      ctrl_q      <= 2'b00;
      prescale_q  <= 8'h00;
      period_sh_q <= 8'h00;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh_q[n] <= 8'h00;
      end
    end else begin
      wr_q <= b_write_i;
      if (commit) begin
        case (b_addr_i)
          ADDR_CTRL:     ctrl_q      <= b_data_i[1:0];
          ADDR_PRESCALE: prescale_q  <= b_data_i;
          ADDR_PERIOD:   period_sh_q <= b_data_i;
          default: begin
            for (int n = 0; n < NUM_CH; n++) begin
              if (b_addr_i == DUTY_BASE + 8'(n)) begin
                duty_sh_q[n] <= b_data_i;
              end
            end
          end
        endcase
      end
    end
  end

  // Read mux always returns the shadow copy; unmapped addresses read zero
  always_comb begin
    b_data_o = 8'h00;
    case (b_addr_i)
      ADDR_CTRL:     b_data_o = {6'b000000, ctrl_q};
      ADDR_PRESCALE: b_data_o = prescale_q;
      ADDR_PERIOD:   b_data_o = period_sh_q;
      ADDR_ID:       b_data_o = ID_VALUE;
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (b_addr_i == DUTY_BASE + 8'(n)) begin
            b_data_o = duty_sh_q[n];
          end
        end
      end
    endcase
  end

  // Prescaler and period counter; both park at zero while disabled
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      pcnt_q       <= 8'h00;
      cnt_q        <= 8'h00;
      period_act_q <= 8'h00;
    end else if (!en) begin
      pcnt_q       <= 8'h00;
      cnt_q        <= 8'h00;
      period_act_q <= period_sh_q;
    end else begin
      pcnt_q <= tick ? 8'h00 : pcnt_q + 8'd1;
      if (tick) begin
        cnt_q <= wrap ? 8'h00 : cnt_q + 8'd1;
      end
      if (wrap) begin
        period_act_q <= period_sh_q;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel u_ch (
      .clk_i  (clk_i),
      .nrst_i (nrst_i),
      .en_i   (en),
      .inv_i  (inv),
      .load_i (load_act),
      .duty_i (duty_sh_q[g]),
      .cnt_i  (cnt_q),
      .pwm_o  (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_pwm_regbank.sv
// tb/tb_pwm_regbank.sv - directed self-checking bench for pwm_regbank
module tb_pwm_regbank;
  import pwm_pkg::*;

  localparam int NUM_CH = 8;

  logic              clk_i     = 1'b0;
  logic              nrst_i    = 1'b0;
  logic [7:0]        b_addr_i  = 8'h00;
  logic [7:0]        b_data_i  = 8'h00;
  logic              b_write_i = 1'b0;
  logic [7:0]        b_data_o;
  logic [NUM_CH-1:0] pwm_o;
  logic              period_o;

  int checks   = 0;
  int failures = 0;
  int hi;
  int len;
  int pulses;

  pwm_regbank #(
    .NUM_CH    (NUM_CH),
    .DUTY_BASE (8'h10),
    .ID_VALUE  (8'hA5)
  ) dut (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .b_addr_i  (b_addr_i),
    .b_data_i  (b_data_i),
    .b_write_i (b_write_i),
    .b_data_o  (b_data_o),
    .pwm_o     (pwm_o),
    .period_o  (period_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_i);
    b_addr_i  = a;
    b_data_i  = d;
    b_write_i = 1'b1;
    @(negedge clk_i);
    b_write_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic held_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk_i);
    b_addr_i  = a;
    b_data_i  = d;
    b_write_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      b_data_i = d + 8'(i) + 8'd1;
    end
    b_write_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    b_addr_i = a;
    #1;
    check(tag, {24'h0, b_data_o}, {24'h0, exp});
  endtask

  // Waits for a period_o pulse, then counts high cycles of one channel up to the next pulse
  task automatic measure(input int ch, output int high, output int plen);
    int n;
    n = 0;
    while (!period_o && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 400) begin
      high = -1;
      plen = -1;
      return;
    end
    high = 0;
    plen = 0;
    do begin
      @(negedge clk_i);
      plen++;
      if (pwm_o[ch]) high++;
    end while (!period_o && plen < 400);
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    nrst_i = 1'b1;
    @(negedge clk_i);

    read_check("rst_ctrl", 8'h00, 8'h00);
    read_check("rst_prescale", 8'h01, 8'h00);
    read_check("rst_period", 8'h02, 8'h00);
    read_check("rst_id", 8'h03, 8'hA5);
    read_check("rst_duty0", 8'h10, 8'h00);
    check("rst_pwm", {24'h0, pwm_o}, 32'h0);
    check("rst_period_o", {31'h0, period_o}, 32'h0);

    bus_write(ADDR_PRESCALE, 8'h01);
    bus_write(ADDR_PERIOD, 8'h09);
    bus_write(8'h10, 8'h03);
    bus_write(ADDR_CTRL, 8'h01);
    measure(0, hi, len);
    check("d3_high_a", hi, 6);
    check("d3_len_a", len, 20);
    measure(0, hi, len);
    check("d3_high_b", hi, 6);
    check("d3_len_b", len, 20);

    bus_write(8'h10, 8'h07);
    read_check("d7_readback", 8'h10, 8'h07);
    repeat (5) @(negedge clk_i);
    check("d7_not_yet_active", {31'h0, pwm_o[0]}, 32'h0);
    measure(0, hi, len);
    check("d7_high", hi, 14);
    check("d7_len", len, 20);

    bus_write(8'h11, 8'h00);
    bus_write(8'h12, 8'hFF);
    measure(1, hi, len);
    measure(1, hi, len);
    check("d0_high", hi, 0);
    check("d0_len", len, 20);
    measure(2, hi, len);
    check("dff_high", hi, 20);

    bus_write(ADDR_CTRL, 8'hFF);
    read_check("ctrl_upper_zero", ADDR_CTRL, 8'h03);
    measure(1, hi, len);
    check("inv_d0_high", hi, 20);
    measure(2, hi, len);
    check("inv_dff_high", hi, 0);

    bus_write(ADDR_CTRL, 8'h02);
    check("dis_inv_pwm", {24'h0, pwm_o}, 32'hFF);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (period_o) pulses++;
    end
    check("dis_no_period", pulses, 0);
    check("dis_inv_pwm_hold", {24'h0, pwm_o}, 32'hFF);

    held_write(ADDR_PRESCALE, 8'h33);
    read_check("held_one_commit", ADDR_PRESCALE, 8'h33);
    held_write(ADDR_ID, 8'h5C);
    read_check("held_id_ro", ADDR_ID, 8'hA5);
    held_write(8'h7F, 8'h66);
    read_check("unmapped_zero", 8'h7F, 8'h00);
    read_check("period_intact", ADDR_PERIOD, 8'h09);

    bus_write(ADDR_PRESCALE, 8'h01);
    bus_write(ADDR_CTRL, 8'h01);
    repeat (3) @(negedge clk_i);
    check("pre_rst_pwm2_high", {31'h0, pwm_o[2]}, 32'h1);
    #2;
    nrst_i = 1'b0;
    #1;
    check("async_rst_pwm", {24'h0, pwm_o}, 32'h0);
    check("async_rst_period_o", {31'h0, period_o}, 32'h0);
    @(negedge clk_i);
    nrst_i = 1'b1;
    read_check("rst2_ctrl", ADDR_CTRL, 8'h00);
    read_check("rst2_prescale", ADDR_PRESCALE, 8'h00);
    read_check("rst2_period", ADDR_PERIOD, 8'h00);
    read_check("rst2_id", ADDR_ID, 8'hA5);
    read_check("rst2_duty0", 8'h10, 8'h00);
    read_check("rst2_duty2", 8'h12, 8'h00);
    check("rst2_pwm", {24'h0, pwm_o}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
